// File: rtl/conv_maxpool_row.sv
// conv_maxpool_row: streaming 2x2/stride-2 max-pool over conv output rows.
// Optional fused ReLU on input elements when MAXPOOL_RELU_EN is defined.
module conv_maxpool_row #(
  parameter int DATA_WIDTH = 8,
  parameter int D          = 4,
  parameter int W          = 12,
  parameter int H          = 12
) (
  input  logic                            clk,
  input  logic                            rstn_i,
  input  logic                            image_start_i,
  input  logic [D*W*DATA_WIDTH-1:0]       row_i,
  input  logic                            row_valid_i,
  output logic [D*(W/2)*DATA_WIDTH-1:0]   pool_o,
  output logic                            pool_valid_o,
  output logic                            frame_done_o
);
  localparam int HW = W / 2;
  localparam int HB = D * HW * DATA_WIDTH;
  localparam int CW = (H > 1) ? $clog2(H) : 1;
  typedef enum logic {EVEN, ODD} state_t;
  state_t          state_q, state_eff;
  logic [CW-1:0]   row_cnt_q, cnt_eff;
  logic [HB-1:0]   buf_q, h_d, pool_d, pool_q;
  logic            pool_valid_q, frame_done_q, last_row;
  function automatic logic signed [DATA_WIDTH-1:0] smax(
    input logic signed [DATA_WIDTH-1:0] a,
    input logic signed [DATA_WIDTH-1:0] b);
    return (a > b) ? a : b;
  endfunction
  function automatic logic signed [DATA_WIDTH-1:0] act(input logic signed [DATA_WIDTH-1:0] v);
`ifdef MAXPOOL_RELU_EN
    return v[DATA_WIDTH-1] ? '0 : v;
`else
    return v;
`endif
  endfunction
  always_comb begin
    h_d    = '0;
    pool_d = '0;
    for (int d = 0; d < D; d++) begin
      for (int x = 0; x < HW; x++) begin
        h_d[(d*HW+x)*DATA_WIDTH +: DATA_WIDTH] =
          smax(act(row_i[(d*W+2*x)*DATA_WIDTH +: DATA_WIDTH]),
               act(row_i[(d*W+2*x+1)*DATA_WIDTH +: DATA_WIDTH]));
        pool_d[(d*HW+x)*DATA_WIDTH +: DATA_WIDTH] =
          smax(buf_q[(d*HW+x)*DATA_WIDTH +: DATA_WIDTH],
               h_d[(d*HW+x)*DATA_WIDTH +: DATA_WIDTH]);
      end
    end
  end
  // A start pulse takes effect before a coincident row is classified.
  assign state_eff = image_start_i ? EVEN : state_q;
  assign cnt_eff   = image_start_i ? '0 : row_cnt_q;
  assign last_row  = (cnt_eff == CW'(H - 1));
  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q      <= EVEN;
      row_cnt_q    <= '0;
      buf_q        <= '0;
      pool_q       <= '0;
      pool_valid_q <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      pool_valid_q <= 1'b0;
      frame_done_q <= 1'b0;
      if (row_valid_i && state_eff == EVEN) begin
        buf_q     <= h_d;
        state_q   <= ODD;
        row_cnt_q <= cnt_eff + 1'b1;
      end else if (row_valid_i) begin
        pool_q       <= pool_d;
        pool_valid_q <= 1'b1;
        frame_done_q <= last_row;
        state_q      <= EVEN;
        row_cnt_q    <= last_row ? '0 : cnt_eff + 1'b1;
      end else if (image_start_i) begin
        state_q   <= EVEN;
        row_cnt_q <= '0;
      end
    end
  end
  assign pool_o       = pool_q;
  assign pool_valid_o = pool_valid_q;
  assign frame_done_o = frame_done_q;
endmodule

// File: tb/tb_conv_maxpool_row.sv
// tb_conv_maxpool_row: directed self-checking bench for conv_maxpool_row.
module tb_conv_maxpool_row;
  localparam int RB = 4 * 12 * 8;
  localparam int PB = 4 * 6 * 8;
  logic          clk = 1'b0;
  logic          rstn_i = 1'b0;
  logic          image_start_i = 1'b0;
  logic [RB-1:0] row_i = '0;
  logic          row_valid_i = 1'b0;
  logic [PB-1:0] pool_o;
  logic          pool_valid_o, frame_done_o;
  int checks = 0, failures = 0, pulses = 0;
  always #5 clk = ~clk;
  conv_maxpool_row dut (
    .clk(clk), .rstn_i(rstn_i), .image_start_i(image_start_i),
    .row_i(row_i), .row_valid_i(row_valid_i),
    .pool_o(pool_o), .pool_valid_o(pool_valid_o), .frame_done_o(frame_done_o)
  );
  task automatic chk(input string tag, input logic [PB-1:0] got, input logic [PB-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  function automatic logic [RB-1:0] const_row(input logic [7:0] v);
    logic [RB-1:0] r;
    r = '0;
    for (int i = 0; i < 48; i++) r[i*8 +: 8] = v;
    return r;
  endfunction
  function automatic logic [PB-1:0] const_pool(input logic [7:0] v);
    logic [PB-1:0] p;
    p = '0;
    for (int i = 0; i < 24; i++) p[i*8 +: 8] = v;
    return p;
  endfunction
  function automatic logic [RB-1:0] ramp_row(input int m);
    logic [RB-1:0] r;
    r = '0;
    for (int d = 0; d < 4; d++)
      for (int c = 0; c < 12; c++) r[(d*12+c)*8 +: 8] = 8'(m * c + d);
    return r;
  endfunction
  // Drive one strobe; returns at the following negedge where outputs are valid.
  task automatic send_row(input logic [RB-1:0] r, input logic start);
    row_i = r;
    row_valid_i = 1'b1;
    image_start_i = start;
    @(negedge clk);
    row_valid_i = 1'b0;
    image_start_i = 1'b0;
  endtask
  task automatic start_pulse();
    image_start_i = 1'b1;
    @(negedge clk);
    image_start_i = 1'b0;
  endtask
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask
  initial begin
    logic [PB-1:0] exp_ramp;
    logic [7:0] neg_exp;
    idle(3);
    chk("rst_pool", pool_o, '0);
    chk("rst_pv", PB'(pool_valid_o), '0);
    rstn_i = 1'b1;
    idle(3);
    chk("idle_pool", pool_o, '0);
    chk("idle_pv", PB'(pool_valid_o), '0);
    chk("idle_fd", PB'(frame_done_o), '0);
    send_row(const_row(8'h05), 1'b0);
    chk("c_even_pv", PB'(pool_valid_o), '0);
    idle(9);
    send_row(const_row(8'h03), 1'b0);
    chk("c_pv", PB'(pool_valid_o), 1);
    chk("c_pool", pool_o, const_pool(8'h05));
    chk("c_fd", PB'(frame_done_o), '0);
    idle(1);
    chk("c_pv_pulse", PB'(pool_valid_o), '0);
    chk("c_hold", pool_o, const_pool(8'h05));
    exp_ramp = '0;
    for (int d = 0; d < 4; d++)
      for (int x = 0; x < 6; x++) exp_ramp[(d*6+x)*8 +: 8] = 8'(4 * x + 2 + d);
    send_row(ramp_row(1), 1'b0);
    send_row(ramp_row(2), 1'b0);
    chk("ramp_pv", PB'(pool_valid_o), 1);
    chk("ramp_pool", pool_o, exp_ramp);
    start_pulse();
    for (int r = 0; r < 12; r++) begin
      send_row(const_row(8'(r + 1)), 1'b0);
      if (pool_valid_o) pulses++;
      chk($sformatf("img_pv%0d", r), PB'(pool_valid_o), PB'(r % 2));
      chk($sformatf("img_fd%0d", r), PB'(frame_done_o), PB'(r == 11));
    end
    chk("img_pulses", PB'(pulses), PB'(6));
    chk("img_last_pool", pool_o, const_pool(8'd12));
    send_row(const_row(8'h40), 1'b0);
    chk("wrap_even_pv", PB'(pool_valid_o), '0);
    send_row(const_row(8'h41), 1'b0);
    chk("wrap_odd_pv", PB'(pool_valid_o), 1);
    chk("wrap_fd", PB'(frame_done_o), '0);
    chk("wrap_pool", pool_o, const_pool(8'h41));
    start_pulse();
    send_row(const_row(8'h50), 1'b0);
    send_row(const_row(8'h51), 1'b0);
    send_row(const_row(8'h70), 1'b0);
    idle(2);
    start_pulse();
    send_row(const_row(8'h10), 1'b0);
    chk("mid_even_pv", PB'(pool_valid_o), '0);
    send_row(const_row(8'h11), 1'b0);
    chk("mid_odd_pv", PB'(pool_valid_o), 1);
    chk("mid_pool", pool_o, const_pool(8'h11));
    send_row(const_row(8'h60), 1'b0);
    send_row(const_row(8'h20), 1'b1);
    chk("coin_pv", PB'(pool_valid_o), '0);
    send_row(const_row(8'h21), 1'b0);
    chk("coin_odd_pv", PB'(pool_valid_o), 1);
    chk("coin_pool", pool_o, const_pool(8'h21));
    send_row(const_row(8'h7F), 1'b0);
    rstn_i = 1'b0;
    #2;
    chk("arst_pool", pool_o, '0);
    @(negedge clk);
    rstn_i = 1'b1;
    idle(1);
    send_row(const_row(8'h01), 1'b0);
    chk("arst_even_pv", PB'(pool_valid_o), '0);
    send_row(const_row(8'h02), 1'b0);
    chk("arst_pool2", pool_o, const_pool(8'h02));
`ifdef MAXPOOL_RELU_EN
    neg_exp = 8'h00;
`else
    neg_exp = 8'hFE;
`endif
    send_row(const_row(8'hF0), 1'b0);
    send_row(const_row(8'hFE), 1'b0);
    chk("neg_pv", PB'(pool_valid_o), 1);
    chk("neg_pool", pool_o, const_pool(neg_exp));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
